// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
// Holds the default geometry, the per-stage record layout and the signed
// saturation limit helpers.
package addsub_pkg;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultChunk = 4;

    // Widest operand the saturation helpers can describe.
    localparam int unsigned MaxWidth = 64;

    // Per-stage record at the default width. The top declares the same layout
    // sized by its own WIDTH parameter.
    typedef struct packed {
        logic                    valid;
        logic                    sub;
        logic                    sat;
        logic                    carry;
        logic [DefaultWidth-1:0] a;
        logic [DefaultWidth-1:0] b;    // already inverted for subtract
        logic [DefaultWidth-1:0] sum;  // chunks below the current stage are final
    } stage_t;

    // Largest signed value of the given width (0x7F..F), zero-extended.
    function automatic logic [MaxWidth-1:0] sat_max(input int unsigned width);
        return (MaxWidth'(1) << (width - 1)) - MaxWidth'(1);
    endfunction

    // Most negative signed value of the given width (0x80..0), zero-extended.
    function automatic logic [MaxWidth-1:0] sat_min(input int unsigned width);
        return MaxWidth'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational CHUNK-bit ripple-carry adder slice.
// Ports:
//   a, b  - operand chunks (b already inverted for subtract)
//   cin   - carry into bit 0
//   sum   - chunk sum
//   cout  - carry out of the top bit
module addsub_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[CHUNK];
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with optional signed saturation.
// The operand is processed CHUNK bits per stage with a registered inter-stage
// carry; a final output register applies overflow detection and saturation.
// The whole pipeline stalls together when the output is held.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - input handshake
//   in_a, in_b            - operands
//   in_sub                - 1: A-B, 0: A+B
//   in_sat                - 1: clamp signed overflow
//   out_valid/out_ready   - output handshake
//   out_sum               - result
//   out_cout              - raw carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf               - signed overflow (reported even when saturated)
//   out_zero              - out_sum == 0 after saturation
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,  // must be a multiple of CHUNK
    parameter int unsigned CHUNK = DefaultChunk   // at least 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int unsigned Last   = STAGES - 1;

    localparam logic [WIDTH-1:0] SatMax = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SatMin = WIDTH'(sat_min(WIDTH));

    typedef struct packed {
        logic             valid;
        logic             sub;
        logic             sat;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } pipe_stage_t;

    pipe_stage_t      st_q [STAGES];
    pipe_stage_t      st_d [STAGES];
    logic [CHUNK-1:0] sl_sum  [STAGES];
    logic             sl_cout [STAGES];

    logic             advance;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_sum;
    logic             res_ovf;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Slice k works on chunk k of the record held in stage register k.
    for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
        addsub_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a    (st_q[k].a[k*CHUNK +: CHUNK]),
            .b    (st_q[k].b[k*CHUNK +: CHUNK]),
            .cin  (st_q[k].carry),
            .sum  (sl_sum[k]),
            .cout (sl_cout[k])
        );
    end

    always_comb begin
        // Stage 0 captures operands; data only moves when a transaction is present.
        st_d[0]       = st_q[0];
        st_d[0].valid = in_valid;
        if (in_valid) begin
            st_d[0].a     = in_a;
            st_d[0].b     = in_b ^ {WIDTH{in_sub}};
            st_d[0].sub   = in_sub;
            st_d[0].sat   = in_sat;
            st_d[0].carry = in_sub;
            st_d[0].sum   = '0;
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            st_d[k]                          = st_q[k-1];
            st_d[k].sum[(k-1)*CHUNK +: CHUNK] = sl_sum[k-1];
            st_d[k].carry                    = sl_cout[k-1];
        end
    end

    always_comb begin
        raw_sum                         = st_q[Last].sum;
        raw_sum[Last*CHUNK +: CHUNK]    = sl_sum[Last];
        res_ovf = (st_q[Last].a[WIDTH-1] == st_q[Last].b[WIDTH-1]) &&
                  (raw_sum[WIDTH-1] != st_q[Last].a[WIDTH-1]);
        res_sum = raw_sum;
        if (st_q[Last].sat && res_ovf) begin
            res_sum = st_q[Last].a[WIDTH-1] ? SatMin : SatMax;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                st_q[k] <= '0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                st_q[k] <= st_d[k];
            end
            out_valid <= st_q[Last].valid;
            // Bubbles leave the previous result in place rather than garbage.
            if (st_q[Last].valid) begin
                out_sum  <= res_sum;
                out_cout <= sl_cout[Last];
                out_ovf  <= res_ovf;
                out_zero <= (res_sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe at WIDTH=16, CHUNK=4.
module tb_addsub_pipe;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned STAGES = WIDTH / CHUNK;
    localparam int          N      = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              in_sub;
    logic              in_sat;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_sum;
    logic              out_cout;
    logic              out_ovf;
    logic              out_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic [15:0] ra [N];
    logic [15:0] rb [N];
    logic        rs [N];
    logic        rt [N];

    always #5 clk = ~clk;

    addsub_pipe #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    // Reference: exact signed arithmetic, then range check and clamp.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic sat);
        res_t r;
        int   sa;
        int   sb;
        int   exact;
        sa     = $signed(a);
        sb     = $signed(b);
        exact  = sub ? sa - sb : sa + sb;
        r.ovf  = (exact > 32767) || (exact < -32768);
        if (sub) r.cout = (a >= b);
        else     r.cout = (32'(a) + 32'(b)) > 32'd65535;
        if (sat && r.ovf) r.sum = (exact > 0) ? 16'h7FFF : 16'h8000;
        else              r.sum = exact[15:0];
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t obs, input res_t exp);
        check({tag, "_sum"},  32'(obs.sum),  32'(exp.sum));
        check({tag, "_cout"}, 32'(obs.cout), 32'(exp.cout));
        check({tag, "_ovf"},  32'(obs.ovf),  32'(exp.ovf));
        check({tag, "_zero"}, 32'(obs.zero), 32'(exp.zero));
    endtask

    // One transaction into an idle pipe; lat counts falling edges from the
    // accept cycle to the first one with out_valid seen.
    task automatic single(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic sat, output res_t r, output int lat);
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_sat    = sat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r.sum  = out_sum;
        r.cout = out_cout;
        r.ovf  = out_ovf;
        r.zero = out_zero;
    endtask

    task automatic run_stream(input bit stall, input string tag);
        res_t q[$];
        res_t exp;
        res_t obs;
        res_t prev;
        logic prev_stall = 1'b0;
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        int   first_acc = -1;
        int   first_out = -1;
        int   last_out = -1;
        while (got < N && cyc < 2000) begin
            @(negedge clk);
            out_ready = stall ? ($urandom_range(0, 9) >= 4) : 1'b1;
            in_valid  = (sent < N);
            if (sent < N) begin
                in_a   = ra[sent];
                in_b   = rb[sent];
                in_sub = rs[sent];
                in_sat = rt[sent];
            end
            #1;
            obs.sum  = out_sum;
            obs.cout = out_cout;
            obs.ovf  = out_ovf;
            obs.zero = out_zero;
            check({tag, "_in_ready"}, 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check_res({tag, "_hold"}, obs, prev);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({tag, "_unexpected_out"}, 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    check_res({tag, "_data"}, obs, exp);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b, in_sub, in_sat));
                if (first_acc < 0) first_acc = cyc;
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = obs;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_count"}, 32'(got), 32'(N));
        check({tag, "_leftover"}, 32'(q.size()), 32'd0);
        if (!stall) begin
            // Result rises on the STAGES-th edge after the accept edge.
            check({tag, "_latency"}, 32'(first_out - first_acc), 32'(STAGES + 1));
            check({tag, "_rate"}, 32'(last_out - first_out), 32'(N - 1));
        end
    endtask

    initial begin
        res_t r;
        res_t e;
        int   lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_sat    = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_cout",  32'(out_cout),  32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed boundary cases.
        single(16'h7FFF, 16'h0001, 1'b0, 1'b0, r, lat);
        check("add_ovf_lat", 32'(lat), 32'(STAGES + 1));
        e = '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
        check_res("add_ovf", r, e);
        single(16'h7FFF, 16'h0001, 1'b0, 1'b1, r, lat);
        e = '{sum: 16'h7FFF, cout: 1'b0, ovf: 1'b1, zero: 1'b0};
        check_res("add_ovf_sat", r, e);
        single(16'h0005, 16'h0007, 1'b1, 1'b0, r, lat);
        e = '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        check_res("sub_borrow", r, e);
        single(16'h1234, 16'h1234, 1'b1, 1'b0, r, lat);
        e = '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, zero: 1'b1};
        check_res("sub_zero", r, e);
        single(16'h8000, 16'h0001, 1'b1, 1'b1, r, lat);
        e = '{sum: 16'h8000, cout: 1'b1, ovf: 1'b1, zero: 1'b0};
        check_res("sub_ovf_sat", r, e);
        single(16'h8000, 16'h0001, 1'b1, 1'b0, r, lat);
        e = '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0};
        check_res("sub_ovf", r, e);

        // Random streams, full rate then with back-pressure.
        for (int i = 0; i < N; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rs[i] = 1'($urandom);
            rt[i] = 1'($urandom);
        end
        run_stream(1'b0, "full_rate");
        run_stream(1'b1, "stalled");

        // Fill the pipe under back-pressure, then reset mid-flight.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_sub   = 1'($urandom);
            in_sat   = 1'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_in_ready",  32'(in_ready),  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        single(16'h4321, 16'h1111, 1'b0, 1'b0, r, lat);
        check("post_rst_lat", 32'(lat), 32'(STAGES + 1));
        check_res("post_rst", r, model(16'h4321, 16'h1111, 1'b0, 1'b0));

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. Successor to the team's 4-bit ripple-carry add/sub.
- Operand width is split into CHUNK-bit ripple slices. The carry between slices is registered, so each slice occupies one pipeline stage.
- Adds a per-transaction op select, optional signed saturation, status flags and a valid/ready handshake on both sides.
- Sits between operand-issue logic and downstream result consumers in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; must be at least 1.
- STAGES, WIDTH/CHUNK, derived, not overridable; pipeline depth.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction present
- in_ready  out  1  block can accept a transaction this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  0 = A+B, 1 = A-B (B inverted, carry-in 1)
- in_sat  in  1  1 = clamp signed overflow to the signed max/min
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of the MSB; for subtract, 1 = no borrow
- out_ovf  out  1  signed overflow occurred (reported even when saturated)
- out_zero  out  1  out_sum == 0 after saturation

Behaviour:
- Clocking/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: every stage valid bit, out_valid, out_sum, out_cout, out_ovf and out_zero are 0. in_ready is 1 after reset.
- Pipeline advance:
  - advance = !out_valid || out_ready; this is a global stall.
  - in_ready = advance.
  - Transfer on the input side is in_valid && in_ready. Transfer on the output side is out_valid && out_ready.
- Stage k (0..STAGES-1) adds chunk k of A with chunk k of (B XOR {WIDTH{sub}}), plus carry-in.
  - Carry-in is sub for k=0, otherwise the carry registered by stage k-1.
  - Each stage carries forward: remaining operand chunks, completed sum chunks, carry, sub, sat and valid.
- Latency:
  - An accepted transaction appears on out_valid exactly STAGES cycles after the accept edge, provided out_ready is 1 throughout.
  - Throughput is one transaction per cycle. Bubbles are not collapsed.
- Overflow: ovf = (a_msb == b'_msb) && (raw_msb != a_msb), where b' is B after the sub inversion.
- Saturation: when sat=1 and ovf=1, the result is 0x7F..F if a_msb=0, else 0x80..0. cout is still the raw carry.
- Stall: while out_valid && !out_ready, all stage registers and outputs hold and in_ready=0. No data is lost, duplicated or reordered.
- Simultaneous events: output accept and input accept in the same cycle are allowed and are the normal full-rate case.
- Reset mid-operation: all in-flight transactions are discarded and out_valid drops to 0 immediately (asynchronously).
- Operand inputs are ignored when in_valid=0. Output data is don't-care when out_valid=0, but remains at its last value (no X) in RTL.

Decomposition:
- Package addsub_pkg holds:
  - the default WIDTH/CHUNK constants;
  - a stage_t struct: valid, sub, sat, carry, a, b, sum;
  - functions sat_max(WIDTH) and sat_min(WIDTH).
- One sub-module, addsub_slice: a combinational CHUNK-bit ripple add of a, b', cin, producing sum and cout. It is instantiated once per stage by a generate loop. The top level owns all registers and the handshake.

Test Plan (WIDTH=16, CHUNK=4, STAGES=4):
- Add 0x7FFF + 0x0001, sat=0 -> out_sum 0x8000, cout 0, ovf 1, zero 0. Same with sat=1 -> out_sum 0x7FFF, ovf 1.
- Sub 0x0005 - 0x0007 -> 0xFFFE, cout 0 (borrow), ovf 0. Sub 0x1234 - 0x1234 -> 0x0000, cout 1, zero 1.
- Sub 0x8000 - 0x0001, sat=1 -> 0x8000, ovf 1. Same with sat=0 -> 0x7FFF, ovf 1.
- 32 random back-to-back transactions with out_ready held 1 -> first out_valid exactly 4 cycles after the first accept, then one result per cycle, all matching the reference model in order.
- Same 32 transactions with out_ready randomly deasserted (~40%) -> in_ready tracks advance, outputs stay stable while stalled, no loss or duplication, order preserved.
- Reset asserted with 3 transactions in flight and out_valid=1 -> out_valid drops to 0 without a clock edge. After release, in_ready=1 and the next transaction emerges after 4 cycles with a correct result.
